cpu_mem_loader: RTL

//  Boot loader in front of the cpu top. Accepts a valid/ready word stream and writes the

---
 rtl/cpu_mem_loader.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_mem_loader.sv
// Boot loader for the cpu: streams imem_len words into instruction memory, then dmem_len
// words into data memory, then enables the cpu until stop is seen.
module cpu_mem_loader #(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 11,
    parameter int IMEM_WORDS  = 512,
    parameter int DMEM_WORDS  = 1024,
    parameter int ADDR_STRIDE = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [CNT_W-1:0]  imem_len,
    input  logic [CNT_W-1:0]  dmem_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [31:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    output logic [31:0]       addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [DATA_W-1:0] wdata_ext_2,
    output logic              cpu_enable,
    output logic              busy,
    output logic              error
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_I = 3'd1,
        ST_LOAD_D = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RUN    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] IMEM_MAX = CNT_W'(IMEM_WORDS);
    localparam logic [CNT_W-1:0] DMEM_MAX = CNT_W'(DMEM_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [31:0]      STRIDE   = 32'(ADDR_STRIDE);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    ilen_r;
    logic [CNT_W-1:0]    dlen_r;
    logic                error_r;
    logic                cpu_enable_r;
    logic                wen_i_r;
    logic                wen_d_r;
    logic [31:0]         addr_i_r;
    logic [31:0]         addr_d_r;
    logic [DATA_W-1:0]   wdata_i_r;
    logic [DATA_W-1:0]   wdata_d_r;
    logic                beat_s;
    logic                len_ok_s;
    logic                last_i_s;
    logic                last_d_s;
    logic [31:0]         addr_s;

    assign s_ready     = (state_r == ST_LOAD_I) || (state_r == ST_LOAD_D);
    assign busy        = s_ready || (state_r == ST_DRAIN);
    assign beat_s      = s_valid && s_ready;
    assign len_ok_s    = (imem_len <= IMEM_MAX) && (dmem_len <= DMEM_MAX);
    assign last_i_s    = (state_r == ST_LOAD_I) && (cnt_r == (ilen_r - CNT_ONE));
    assign last_d_s    = (state_r == ST_LOAD_D) && (cnt_r == (dlen_r - CNT_ONE));
    assign addr_s      = 32'(cnt_r) * STRIDE;

    assign ren_ext     = 1'b0;
    assign ren_ext_2   = 1'b0;
    assign wen_ext     = wen_i_r;
    assign wen_ext_2   = wen_d_r;
    assign addr_ext    = addr_i_r;
    assign addr_ext_2  = addr_d_r;
    assign wdata_ext   = wdata_i_r;
    assign wdata_ext_2 = wdata_d_r;
    assign cpu_enable  = cpu_enable_r;
    assign error       = error_r;

    // Next-state decode; zero lengths skip straight past the empty load phases.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && len_ok_s) begin
                    if (imem_len != '0) begin
                        state_nxt_s = ST_LOAD_I;
                    end else if (dmem_len != '0) begin
                        state_nxt_s = ST_LOAD_D;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD_I: begin
                if (beat_s && last_i_s) begin
                    state_nxt_s = (dlen_r != '0) ? ST_LOAD_D : ST_DRAIN;
                end else begin
                    state_nxt_s = ST_LOAD_I;
                end
            end
            ST_LOAD_D: begin
                if (beat_s && last_d_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_LOAD_D;
                end
            end
            ST_DRAIN: state_nxt_s = ST_RUN;
            ST_RUN: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Length latches, word counter and sticky error flag.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_r   <= '0;
            ilen_r  <= '0;
            dlen_r  <= '0;
            error_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start) begin
            if (len_ok_s) begin
                ilen_r  <= imem_len;
                dlen_r  <= dmem_len;
                cnt_r   <= '0;
                error_r <= 1'b0;
            end else begin
                error_r <= 1'b1;
            end
        end else if (beat_s) begin
            cnt_r <= (last_i_s || last_d_s) ? '0 : (cnt_r + CNT_ONE);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Registered write ports; address and data hold between strobes.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wen_i_r   <= 1'b0;
            wen_d_r   <= 1'b0;
            addr_i_r  <= 32'd0;
            addr_d_r  <= 32'd0;
            wdata_i_r <= '0;
            wdata_d_r <= '0;
        end else begin
            wen_i_r <= beat_s && (state_r == ST_LOAD_I);
            wen_d_r <= beat_s && (state_r == ST_LOAD_D);
            if (beat_s && (state_r == ST_LOAD_I)) begin
                addr_i_r  <= addr_s;
                wdata_i_r <= s_data;
            end
            if (beat_s && (state_r == ST_LOAD_D)) begin
                addr_d_r  <= addr_s;
                wdata_d_r <= s_data;
            end
        end
    end

    // cpu enable follows the registered RUN state, so it rises only after DRAIN.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cpu_enable_r <= 1'b0;
        end else begin
            cpu_enable_r <= (state_nxt_s == ST_RUN);
        end
    end

endmodule
